// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, ALUOp, funct and forward-select values.
package alu_pkg;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned FSEL_W  = 2;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_BAD = 4'b1111;

  localparam logic [OP_W-1:0] ALUOP_MEM    = 2'b00;
  localparam logic [OP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [OP_W-1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [OP_W-1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  localparam logic [FSEL_W-1:0] FWD_REG  = 2'b00;
  localparam logic [FSEL_W-1:0] FWD_EX   = 2'b01;
  localparam logic [FSEL_W-1:0] FWD_WB   = 2'b10;
  localparam logic [FSEL_W-1:0] FWD_REG2 = 2'b11;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to ALU control decode with illegal-encoding flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  control,
  output logic               illegal
);

  always_comb begin
    control = ALU_BAD;
    illegal = 1'b1;
    unique case (alu_op)
      ALUOP_MEM: begin
        control = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_BRANCH: begin
        control = ALU_SUB;
        illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FUNCT_ADD: control = ALU_ADD;
          FUNCT_SUB: control = ALU_SUB;
          FUNCT_AND: control = ALU_AND;
          FUNCT_OR:  control = ALU_OR;
          FUNCT_SLT: control = ALU_SLT;
          default: begin
            control = ALU_BAD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        control = ALU_BAD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX boundary register feeding the execute ALU: decode, operand forwarding,
// valid/stall/flush handshake and a saturating illegal-op debug counter.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [OP_W-1:0]    id_alu_op,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic               id_alu_src,
  input  logic [WIDTH-1:0]   id_rs_data,
  input  logic [WIDTH-1:0]   id_rt_data,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic [FSEL_W-1:0]  fwd_a_sel,
  input  logic [FSEL_W-1:0]  fwd_b_sel,
  input  logic [WIDTH-1:0]   ex_fwd_data,
  input  logic [WIDTH-1:0]   wb_fwd_data,
  input  logic               ex_stall,
  input  logic               ex_flush,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [CTRL_W-1:0]  alu_control,
  output logic               ex_valid,
  output logic               ex_illegal,
  output logic [CNT_W-1:0]   illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CTRL_W-1:0] dec_control;
  logic              dec_illegal;
  logic [WIDTH-1:0]  fwd_a;
  logic [WIDTH-1:0]  fwd_b;
  logic [WIDTH-1:0]  op_b;

  alu_ctrl_decode u_decode (
    .alu_op  (id_alu_op),
    .funct   (id_funct),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  assign id_ready = ~ex_stall;

  // Forward muxes; rt is forwarded even when the immediate wins
  always_comb begin
    fwd_a = id_rs_data;
    fwd_b = id_rt_data;
    case (fwd_a_sel)
      FWD_EX:  fwd_a = ex_fwd_data;
      FWD_WB:  fwd_a = wb_fwd_data;
      default: fwd_a = id_rs_data;
    endcase
    case (fwd_b_sel)
      FWD_EX:  fwd_b = ex_fwd_data;
      FWD_WB:  fwd_b = wb_fwd_data;
      default: fwd_b = id_rt_data;
    endcase
    op_b = id_alu_src ? id_imm : fwd_b;
  end

  // Bubbles carry an all-zero payload so the downstream zero flag is deterministic
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_control   <= ALU_AND;
      ex_valid      <= 1'b0;
      ex_illegal    <= 1'b0;
      illegal_count <= '0;
    end else if (ex_flush || (!ex_stall && !id_valid)) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_AND;
      ex_valid    <= 1'b0;
      ex_illegal  <= 1'b0;
    end else if (!ex_stall) begin
      alu_a       <= fwd_a;
      alu_b       <= op_b;
      alu_control <= dec_control;
      ex_valid    <= 1'b1;
      ex_illegal  <= dec_illegal;
      if (dec_illegal && (illegal_count != CNT_MAX)) begin
        illegal_count <= illegal_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary register that drives the execute-stage ALU; it is the producing end of the ALU's {a, b, control} interface.
- Decodes the 2-bit ALUOp and the 6-bit funct field into the 4-bit ALU control code.
- Selects forwarded operands and the immediate operand, then registers everything behind a valid/stall/flush handshake.
- Also flags illegal ALU encodings and keeps a saturating illegal-op counter for debug.

Parameters:
- WIDTH, 32, datapath width of operands and immediate.
- CNT_W, 8, width of the saturating illegal-op counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- id_valid  in  1  decode stage presents a valid instruction.
- id_ready  out  1  stage can accept: equals ~ex_stall (combinational).
- id_alu_op  in  2  00 mem-address, 01 branch-compare, 10 R-type, 11 reserved.
- id_funct  in  6  R-type funct field.
- id_alu_src  in  1  1 selects id_imm for operand B.
- id_rs_data  in  WIDTH  register-file read A.
- id_rt_data  in  WIDTH  register-file read B.
- id_imm  in  WIDTH  sign-extended immediate.
- fwd_a_sel  in  2  00 regfile, 01 ex_fwd_data, 10 wb_fwd_data, 11 regfile.
- fwd_b_sel  in  2  same encoding for operand B.
- ex_fwd_data  in  WIDTH  EX/MEM forwarded result.
- wb_fwd_data  in  WIDTH  MEM/WB forwarded result.
- ex_stall  in  1  hold registered contents.
- ex_flush  in  1  squash: insert bubble.
- alu_a  out  WIDTH  registered operand A.
- alu_b  out  WIDTH  registered operand B.
- alu_control  out  4  registered control code.
- ex_valid  out  1  registered contents valid.
- ex_illegal  out  1  registered instruction had an illegal ALU encoding.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (rst_n=0 at a clk edge): alu_a=0, alu_b=0, alu_control=4'b0000, ex_valid=0, ex_illegal=0, illegal_count=0. Reset overrides flush, stall and load.
- Decode (combinational, pre-register):
  - alu_op 00 -> 0010 (ADD).
  - alu_op 01 -> 0110 (SUB).
  - alu_op 10, funct 100000 -> 0010 (ADD).
  - alu_op 10, funct 100010 -> 0110 (SUB).
  - alu_op 10, funct 100100 -> 0000 (AND).
  - alu_op 10, funct 100101 -> 0001 (OR).
  - alu_op 10, funct 101010 -> 0111 (SLT).
  - alu_op 10 with any other funct, or alu_op 11 -> control 1111 with illegal=1. The downstream ALU yields 0 for 1111.
- Operand A = forward mux(fwd_a_sel).
- Operand B = id_alu_src ? id_imm : forward mux(fwd_b_sel). Forwarding applies to rt even when the immediate is selected; the forwarded rt value is discarded in that case.
- Per-edge priority: reset > flush > stall > load.
  - Flush: ex_valid=0, ex_illegal=0, alu_control=0000, alu_a=0, alu_b=0. Flush wins over a simultaneous stall.
  - Stall (no flush): all outputs hold, illegal_count holds.
  - Load (no stall, no flush), id_valid=1: register decoded control, operands, illegal flag; ex_valid=1.
  - Load with id_valid=0: bubble, with outputs as for flush.
- illegal_count increments by 1 on each load with id_valid=1 and illegal=1. It saturates at 2^CNT_W-1 with no wrap. It is unaffected by flush and clears only on reset.
- Latency: one cycle from the id_* inputs to the registered outputs. id_ready is combinational with no registered path.
- Outputs are never X after reset. Bubble payload is forced to zero so the downstream zero flag is deterministic.

Decomposition:
- Shared package alu_pkg:
  - ALU control localparams: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_BAD=1111.
  - ALUOp encodings.
  - funct constants.
  - Forward-select encodings.
- One natural sub-module: alu_ctrl_decode (combinational alu_op/funct -> control, illegal). It is reusable by other pipeline variants.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then id_valid=0 -> all outputs 0, id_ready=1.
- R-type decode: sweep funct 20/22/24/25/2A with alu_op=10, id_rs_data=7, id_rt_data=3 -> next cycle control 0010/0110/0000/0001/0111, alu_a=7, alu_b=3, ex_valid=1.
- Immediate with forwarding: alu_op=00, id_alu_src=1, id_imm=0x10, fwd_a_sel=01, ex_fwd_data=0x100 -> alu_a=0x100, alu_b=0x10, control 0010. Repeat with fwd_b_sel=10 and id_alu_src=0, wb_fwd_data=5 -> alu_b=5.
- Stall/flush: load a SUB, assert ex_stall 3 cycles while id inputs change -> outputs hold. Assert ex_stall and ex_flush together -> ex_valid=0, payload 0.
- Illegal encoding: alu_op=10, funct=000000 -> control 1111, ex_illegal=1, illegal_count=1. Same with alu_op=11 -> count=2. A flushed or stalled illegal instruction does not increment.
- Saturation and reset mid-operation: CNT_W=2, issue 5 illegal ops -> count stays at 3. rst_n=0 while ex_stall=1 -> all outputs 0 next edge.
